// File: rtl/vga_layer_compositor_pkg.sv
// Shared definitions for the VGA layer compositor: bus control-field offsets,
// brightness range and the fade controller state type.
package vga_layer_compositor_pkg;

    // Control bits sit directly above the RGB field: {vsync, hsync, vblnk, hblnk}.
    localparam int CTRL_W    = 4;
    localparam int HBLNK_OFS = 0;
    localparam int VBLNK_OFS = 1;
    localparam int HSYNC_OFS = 2;
    localparam int VSYNC_OFS = 3;

    localparam int          LEVEL_W    = 5;
    localparam logic [4:0]  LEVEL_FULL = 5'd16;
    localparam logic [4:0]  LEVEL_ZERO = 5'd0;

    typedef enum logic [1:0] {
        FADE_IDLE    = 2'd0,
        FADE_WAIT_FB = 2'd1,
        FADE_STEP    = 2'd2
    } fade_state_t;

    // One brightness step toward full (up=1) or black (up=0); callers stop at the target.
    function automatic logic [LEVEL_W-1:0] level_toward(input logic [LEVEL_W-1:0] lvl,
                                                        input logic up);
        return up ? lvl + 5'd1 : lvl - 5'd1;
    endfunction

endpackage

// File: rtl/vga_layer_compositor_rgb_scale.sv
// Combinational brightness scaling of one colour channel: (c * level) >> 4.
module vga_layer_compositor_rgb_scale
    import vga_layer_compositor_pkg::*;
#(
    parameter int COLOR_W = 4
) (
    input  logic [COLOR_W-1:0] c_in,
    input  logic [LEVEL_W-1:0] level,
    output logic [COLOR_W-1:0] c_out
);

    logic [COLOR_W+4:0] prod;

    always_comb begin
        prod  = (COLOR_W+5)'(c_in) * (COLOR_W+5)'(level);
        c_out = COLOR_W'(prod >> 4);
    end

endmodule

// File: rtl/vga_layer_compositor.sv
// Priority compositor of overlay layers onto a base VGA bus with a
// frame-synchronous brightness fade; two-stage pipeline (select, scale).
module vga_layer_compositor
    import vga_layer_compositor_pkg::*;
#(
    parameter int LAYERS           = 6,
    parameter int COLOR_W          = 4,
    parameter int FADE_STEP_FRAMES = 2
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic [3*COLOR_W+CTRL_W-1:0]     vga_bus_in,
    input  logic [LAYERS*3*COLOR_W-1:0]     layer_rgb,
    input  logic [LAYERS-1:0]               layer_valid,
    input  logic [LAYERS-1:0]               layer_en,
    input  logic                            fade_req,
    input  logic                            fade_dir,
    output logic [3*COLOR_W+CTRL_W-1:0]     vga_bus_out,
    output logic                            fade_busy,
    output logic                            fade_done,
    output logic [LEVEL_W-1:0]              level
);

    localparam int RGB_W = 3 * COLOR_W;
    localparam int CNT_W = $clog2(FADE_STEP_FRAMES + 1);

    logic                   vblnk_prev_q, vblnk_prev_d;
    logic                   fb;
    logic [LAYERS-1:0]      en_q, en_d;
    logic [RGB_W-1:0]       sel_rgb;
    logic [RGB_W-1:0]       s1_rgb_q, s1_rgb_d;
    logic [CTRL_W-1:0]      s1_ctrl_q, s1_ctrl_d;
    logic [RGB_W-1:0]       scaled_rgb;
    logic [RGB_W+CTRL_W-1:0] out_q, out_d;

    fade_state_t            state_q, state_d;
    logic                   dir_q, dir_d;
    logic [CNT_W-1:0]       cnt_q, cnt_d, cnt_inc;
    logic [LEVEL_W-1:0]     level_q, level_d, target;
    logic                   busy_q, busy_d;
    logic                   done_q, done_d;

    // Frame boundary = first cycle of vertical blanking.
    always_comb begin
        vblnk_prev_d = vga_bus_in[RGB_W+VBLNK_OFS];
        fb           = vga_bus_in[RGB_W+VBLNK_OFS] & ~vblnk_prev_q;
        en_d         = fb ? layer_en : en_q;
    end

    // Ascending scan with last-wins gives the highest enabled, valid layer priority.
    always_comb begin
        sel_rgb = vga_bus_in[RGB_W-1:0];
        for (int k = 0; k < LAYERS; k++) begin
            if (en_q[k] && layer_valid[k]) begin
                sel_rgb = layer_rgb[k*RGB_W +: RGB_W];
            end
        end
        s1_ctrl_d = vga_bus_in[RGB_W +: CTRL_W];
        s1_rgb_d  = (vga_bus_in[RGB_W+HBLNK_OFS] || vga_bus_in[RGB_W+VBLNK_OFS]) ? '0 : sel_rgb;
    end

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : g_scale
            vga_layer_compositor_rgb_scale #(
                .COLOR_W (COLOR_W)
            ) u_scale (
                .c_in  (s1_rgb_q[gi*COLOR_W +: COLOR_W]),
                .level (level_q),
                .c_out (scaled_rgb[gi*COLOR_W +: COLOR_W])
            );
        end
    endgenerate

    always_comb begin
        out_d = {s1_ctrl_q, scaled_rgb};
    end

    // Fade controller: level only moves on frame boundaries, so updates land in blanking.
    always_comb begin
        state_d = state_q;
        dir_d   = dir_q;
        cnt_d   = cnt_q;
        level_d = level_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        target  = dir_q ? LEVEL_FULL : LEVEL_ZERO;
        cnt_inc = cnt_q + 1'b1;
        case (state_q)
            FADE_IDLE: begin
                // A request coinciding with the done pulse is dropped.
                if (fade_req && !done_q) begin
                    dir_d   = fade_dir;
                    busy_d  = 1'b1;
                    state_d = FADE_WAIT_FB;
                end
            end
            FADE_WAIT_FB: begin
                if (fb) begin
                    cnt_d   = '0;
                    state_d = FADE_STEP;
                end
            end
            FADE_STEP: begin
                if (fb) begin
                    if (level_q == target) begin
                        done_d  = 1'b1;
                        busy_d  = 1'b0;
                        state_d = FADE_IDLE;
                    end else if (cnt_inc == CNT_W'(FADE_STEP_FRAMES)) begin
                        cnt_d   = '0;
                        level_d = level_toward(level_q, dir_q);
                    end else begin
                        cnt_d   = cnt_inc;
                    end
                end
            end
            default: state_d = FADE_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            vblnk_prev_q <= 1'b0;
            en_q         <= '0;
            s1_rgb_q     <= '0;
            s1_ctrl_q    <= '0;
            out_q        <= '0;
            state_q      <= FADE_IDLE;
            dir_q        <= 1'b0;
            cnt_q        <= '0;
            level_q      <= LEVEL_FULL;
            busy_q       <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            vblnk_prev_q <= vblnk_prev_d;
            en_q         <= en_d;
            s1_rgb_q     <= s1_rgb_d;
            s1_ctrl_q    <= s1_ctrl_d;
            out_q        <= out_d;
            state_q      <= state_d;
            dir_q        <= dir_d;
            cnt_q        <= cnt_d;
            level_q      <= level_d;
            busy_q       <= busy_d;
            done_q       <= done_d;
        end
    end

    assign vga_bus_out = out_q;
    assign fade_busy   = busy_q;
    assign fade_done   = done_q;
    assign level       = level_q;

endmodule

// File: tb/tb_vga_layer_compositor.sv
// Randomised directed-step bench for vga_layer_compositor against a frame-level
// behavioural model (priority pick, blanking, fade by frames counted since start).
module tb_vga_layer_compositor;
    import vga_layer_compositor_pkg::*;

    localparam int LAYERS  = 6;
    localparam int COLOR_W = 4;
    localparam int FSF     = 2;
    localparam int RGB_W   = 3 * COLOR_W;
    localparam int BUS_W   = RGB_W + CTRL_W;
    localparam int H_ACT   = 12;
    localparam int H_TOT   = 16;
    localparam int V_ACT   = 4;
    localparam int V_TOT   = 6;
    localparam int FRAME   = H_TOT * V_TOT;

    logic                       clk = 1'b0;
    logic                       rst_n = 1'b0;
    logic [BUS_W-1:0]           vga_bus_in = '0;
    logic [LAYERS*RGB_W-1:0]    layer_rgb = '0;
    logic [LAYERS-1:0]          layer_valid = '0;
    logic [LAYERS-1:0]          layer_en = '0;
    logic                       fade_req = 1'b0;
    logic                       fade_dir = 1'b0;
    logic [BUS_W-1:0]           vga_bus_out;
    logic                       fade_busy;
    logic                       fade_done;
    logic [LEVEL_W-1:0]         level;

    vga_layer_compositor #(
        .LAYERS           (LAYERS),
        .COLOR_W          (COLOR_W),
        .FADE_STEP_FRAMES (FSF)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .vga_bus_in  (vga_bus_in),
        .layer_rgb   (layer_rgb),
        .layer_valid (layer_valid),
        .layer_en    (layer_en),
        .fade_req    (fade_req),
        .fade_dir    (fade_dir),
        .vga_bus_out (vga_bus_out),
        .fade_busy   (fade_busy),
        .fade_done   (fade_done),
        .level       (level)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int hcnt  = 0;
    int vcnt  = 0;
    logic [LAYERS-1:0] valid_and = '1;
    logic [LAYERS-1:0] valid_or  = '0;
    logic force_l4_red = 1'b0;
    logic fff_mode     = 1'b0;

    // Reference model state
    logic [LAYERS-1:0] m_en;
    logic              m_prev_vb;
    logic [BUS_W-1:0]  m_pipe;
    logic [BUS_W-1:0]  m_out;
    int                m_level;
    logic              m_busy, m_done, m_started, m_dir;
    int                m_frames;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%h expected=%h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_en      = '0;
        m_prev_vb = 1'b0;
        m_pipe    = '0;
        m_out     = '0;
        m_level   = 16;
        m_busy    = 1'b0;
        m_done    = 1'b0;
        m_started = 1'b0;
        m_dir     = 1'b0;
        m_frames  = 0;
    endtask

    task automatic model_edge();
        logic vb, fb, done_prev;
        logic [RGB_W-1:0] pick;
        logic [BUS_W-1:0] sc;
        if (!rst_n) begin
            model_reset();
        end else begin
            vb = vga_bus_in[RGB_W+VBLNK_OFS];
            fb = vb && !m_prev_vb;
            m_prev_vb = vb;
            // Output of this edge: previously selected pixel scaled by current brightness.
            sc = m_pipe;
            for (int ch = 0; ch < 3; ch++)
                sc[ch*COLOR_W +: COLOR_W] = COLOR_W'((int'(m_pipe[ch*COLOR_W +: COLOR_W]) * m_level) / 16);
            m_out = sc;
            pick = vga_bus_in[RGB_W-1:0];
            for (int k = LAYERS - 1; k >= 0; k--) begin
                if (m_en[k] && layer_valid[k]) begin
                    pick = layer_rgb[k*RGB_W +: RGB_W];
                    break;
                end
            end
            if (vga_bus_in[RGB_W+HBLNK_OFS] || vb) pick = '0;
            m_pipe = {vga_bus_in[BUS_W-1:RGB_W], pick};
            if (fb) m_en = layer_en;
            done_prev = m_done;
            m_done = 1'b0;
            if (m_busy) begin
                if (fb) begin
                    if (!m_started) begin
                        m_started = 1'b1;
                        m_frames  = 0;
                    end else if (m_level == (m_dir ? 16 : 0)) begin
                        m_done = 1'b1;
                        m_busy = 1'b0;
                    end else begin
                        m_frames++;
                        if (m_frames % FSF == 0) m_level = m_dir ? m_level + 1 : m_level - 1;
                    end
                end
            end else if (fade_req && !done_prev) begin
                m_busy    = 1'b1;
                m_dir     = fade_dir;
                m_started = 1'b0;
            end
        end
    endtask

    task automatic check_all(input string phase);
        check({phase, "_bus"},   32'(vga_bus_out), 32'(m_out));
        check({phase, "_level"}, 32'(level),       32'(m_level));
        check({phase, "_busy"},  32'(fade_busy),   32'(m_busy));
        check({phase, "_done"},  32'(fade_done),   32'(m_done));
    endtask

    task automatic tick(input logic req, input string phase);
        logic hb, vb, hs, vs;
        hb = (hcnt >= H_ACT);
        vb = (vcnt >= V_ACT);
        hs = (hcnt >= H_ACT + 1) && (hcnt < H_ACT + 3);
        vs = (vcnt == V_TOT - 1);
        vga_bus_in = {vs, hs, vb, hb, RGB_W'($urandom)};
        for (int k = 0; k < LAYERS; k++) layer_rgb[k*RGB_W +: RGB_W] = RGB_W'($urandom);
        if (force_l4_red) layer_rgb[4*RGB_W +: RGB_W] = 12'hF00;
        if (fff_mode) begin
            vga_bus_in[RGB_W-1:0] = 12'hFFF;
            layer_rgb = '1;
        end
        layer_valid = (LAYERS'($urandom) & valid_and) | valid_or;
        fade_req = req;
        @(posedge clk);
        model_edge();
        hcnt++;
        if (hcnt == H_TOT) begin
            hcnt = 0;
            vcnt = (vcnt + 1) % V_TOT;
        end
        #1;
        check_all(phase);
        fade_req = 1'b0;
    endtask

    task automatic run(input int n, input string phase);
        for (int i = 0; i < n; i++) tick(1'b0, phase);
    endtask

    task automatic run_until_idle(input string phase);
        int n;
        n = 0;
        while (m_busy && n < 40 * FRAME) begin
            tick(1'b0, phase);
            n++;
        end
        check({phase, "_timeout"}, 32'(m_busy), 32'(0));
    endtask

    initial begin
        int n;
        model_reset();
        // Reset state
        rst_n = 1'b0;
        run(3, "reset");
        check("reset_level_const", 32'(level), 32'(16));
        rst_n = 1'b1;

        // Random compositing, all layers enabled
        layer_en = '1;
        run(3 * FRAME, "rand_all");

        // Priority: layers 1 and 4 valid, layer 4 red wins
        valid_and = '0;
        valid_or = 6'b010010;
        force_l4_red = 1'b1;
        run(FRAME, "prio");
        valid_or = '0;
        run(FRAME, "base_only");
        force_l4_red = 1'b0;

        // Enable shadow: change mid-frame, visible only after next frame boundary
        layer_en = '0;
        run(2 * FRAME, "shadow_off");
        while (!(vcnt == 1 && hcnt == 5)) tick(1'b0, "shadow_seek");
        layer_en = 6'b000100;
        valid_or = 6'b000100;
        run(2 * FRAME, "shadow_on");

        // Fade out with full-white pixels (level 8 -> 12'h777)
        layer_en = '1;
        valid_and = '1;
        valid_or = '0;
        fff_mode = 1'b1;
        fade_dir = 1'b0;
        tick(1'b1, "fade_out_req");
        check("fade_out_busy_rise", 32'(fade_busy), 32'(1));
        run_until_idle("fade_out");
        check("fade_out_final_level", 32'(level), 32'(0));
        check("fade_out_done_pulse", 32'(fade_done), 32'(1));
        // Request in the done-pulse cycle is ignored
        fade_dir = 1'b1;
        tick(1'b1, "req_at_done");
        run(FRAME, "dark");
        check("req_at_done_ignored", 32'(fade_busy), 32'(0));
        fff_mode = 1'b0;

        // Fade in to full
        tick(1'b1, "fade_in_req");
        run_until_idle("fade_in");
        check("fade_in_final_level", 32'(level), 32'(16));

        // Already at target; second request while busy has no effect
        run(10, "gap");
        tick(1'b1, "at_target_req");
        run(FRAME / 2, "at_target");
        fade_dir = 1'b0;
        tick(1'b1, "busy_req");
        run_until_idle("at_target_wait");
        check("at_target_level", 32'(level), 32'(16));
        run(FRAME, "after_target");

        // Reset mid-fade at level 5
        fade_dir = 1'b0;
        tick(1'b1, "fade2_req");
        n = 0;
        while (m_level != 5 && n < 40 * FRAME) begin
            tick(1'b0, "fade2");
            n++;
        end
        check("fade2_reached5", 32'(level), 32'(5));
        run(20, "fade2_mid");
        #2;
        rst_n = 1'b0;
        #1;
        model_reset();
        check_all("async_rst");
        check("async_rst_out_zero", 32'(vga_bus_out), 32'(0));
        run(3, "in_rst");
        rst_n = 1'b1;
        run(2 * FRAME, "post_rst");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
